// File: rtl/bkram_seq_if.sv
// Signal bundle between the backup-RAM save sequencer and the core/HPS side.
interface bkram_seq_if;
  logic        download;
  logic        img_mounted;
  logic        img_readonly;
  logic        img_size_nz;
  logic        osd_status;
  logic        load_req;
  logic        save_req;
  logic        format_req;
  logic        autosave;
  logic        bram_wr;
  logic        sd_ack;
  logic [31:0] sd_lba;
  logic        sd_rd;
  logic        sd_wr;
  logic        bk_ena;
  logic        bk_pending;
  logic        bk_busy;
  logic        bk_loading;
  logic        fmt_we;
  logic [7:0]  fmt_addr;

  modport slave (
    input  download, img_mounted, img_readonly, img_size_nz, osd_status,
           load_req, save_req, format_req, autosave, bram_wr, sd_ack,
    output sd_lba, sd_rd, sd_wr, bk_ena, bk_pending, bk_busy, bk_loading,
           fmt_we, fmt_addr
  );

  modport master (
    output download, img_mounted, img_readonly, img_size_nz, osd_status,
           load_req, save_req, format_req, autosave, bram_wr, sd_ack,
    input  sd_lba, sd_rd, sd_wr, bk_ena, bk_pending, bk_busy, bk_loading,
           fmt_we, fmt_addr
  );
endinterface

// File: rtl/bkram_seq.sv
// Backup-RAM save-image sequencer: streams SECTORS sectors to/from the HPS
// for load/save and emits FMT_WORDS header-word writes for a format.
module bkram_seq #(
  parameter int SECTORS   = 16,
  parameter int FMT_WORDS = 4
) (
  input logic        clk_sys,
  input logic        reset,
  bkram_seq_if.slave bus
);

  localparam int               LBA_W    = (SECTORS > 1) ? $clog2(SECTORS) : 1;
  localparam logic [LBA_W-1:0] LBA_LAST = LBA_W'(SECTORS - 1);
  localparam logic [7:0]       FMT_LAST = 8'(FMT_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_XFER = 2'd2,
    S_FMT  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [LBA_W-1:0] lba_q, lba_d;
  logic             rd_q, rd_d;
  logic             wr_q, wr_d;
  logic             ena_q, ena_d;
  logic             pend_q, pend_d;
  logic             busy_q, busy_d;
  logic             loading_q, loading_d;
  logic             fmt_we_q, fmt_we_d;
  logic [7:0]       fmt_addr_q, fmt_addr_d;

  logic load_req_q, save_req_q, format_req_q, download_q, sd_ack_q, osd_q;

  logic load_rise, save_rise, fmt_rise, dl_rise, dl_fall, ack_rise, ack_fall, osd_rise;
  logic auto_go, load_go, save_go;

  assign load_rise = bus.load_req   & ~load_req_q;
  assign save_rise = bus.save_req   & ~save_req_q;
  assign fmt_rise  = bus.format_req & ~format_req_q;
  assign dl_rise   = bus.download   & ~download_q;
  assign dl_fall   = ~bus.download  & download_q;
  assign ack_rise  = bus.sd_ack     & ~sd_ack_q;
  assign ack_fall  = ~bus.sd_ack    & sd_ack_q;
  assign osd_rise  = bus.osd_status & ~osd_q;

  // Start conditions; a sequence only needs bk_ena, format does not.
  assign auto_go = ena_q & bus.img_size_nz & dl_fall;
  assign load_go = ena_q & load_rise;
  assign save_go = ena_q & (save_rise | (bus.autosave & pend_q & osd_rise));

  // Edge-detect history of the command and handshake inputs.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      load_req_q   <= 1'b0;
      save_req_q   <= 1'b0;
      format_req_q <= 1'b0;
      download_q   <= 1'b0;
      sd_ack_q     <= 1'b0;
      osd_q        <= 1'b0;
    end else begin
      load_req_q   <= bus.load_req;
      save_req_q   <= bus.save_req;
      format_req_q <= bus.format_req;
      download_q   <= bus.download;
      sd_ack_q     <= bus.sd_ack;
      osd_q        <= bus.osd_status;
    end
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      lba_q      <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      ena_q      <= 1'b0;
      pend_q     <= 1'b0;
      busy_q     <= 1'b0;
      loading_q  <= 1'b0;
      fmt_we_q   <= 1'b0;
      fmt_addr_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      lba_q      <= lba_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      ena_q      <= ena_d;
      pend_q     <= pend_d;
      busy_q     <= busy_d;
      loading_q  <= loading_d;
      fmt_we_q   <= fmt_we_d;
      fmt_addr_q <= fmt_addr_d;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d    = state_q;
    lba_d      = lba_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    ena_d      = ena_q;
    pend_d     = pend_q;
    busy_d     = busy_q;
    loading_d  = loading_q;
    fmt_we_d   = fmt_we_q;
    fmt_addr_d = fmt_addr_q;

    // A new cart download invalidates the image until a writable one is mounted.
    if (dl_rise) begin
      ena_d = 1'b0;
    end else if (bus.download && bus.img_mounted && !bus.img_readonly) begin
      ena_d = 1'b1;
    end else begin
      ena_d = ena_q;
    end

    if (busy_q) begin
      pend_d = 1'b0;
    end else if (ena_q && !bus.osd_status && bus.bram_wr) begin
      pend_d = 1'b1;
    end else begin
      pend_d = pend_q;
    end

    case (state_q)
      S_IDLE: begin
        if (auto_go || load_go) begin
          state_d   = S_REQ;
          lba_d     = '0;
          rd_d      = 1'b1;
          wr_d      = 1'b0;
          busy_d    = 1'b1;
          loading_d = 1'b1;
        end else if (save_go) begin
          state_d   = S_REQ;
          lba_d     = '0;
          rd_d      = 1'b0;
          wr_d      = 1'b1;
          busy_d    = 1'b1;
          loading_d = 1'b0;
        end else if (fmt_rise) begin
          state_d    = S_FMT;
          fmt_we_d   = 1'b1;
          fmt_addr_d = 8'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        if (ack_rise) begin
          state_d = S_XFER;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
        end else begin
          state_d = S_REQ;
        end
      end
      S_XFER: begin
        if (ack_fall && (lba_q == LBA_LAST)) begin
          state_d   = S_IDLE;
          busy_d    = 1'b0;
          loading_d = 1'b0;
        end else if (ack_fall) begin
          // Direction of the re-issued request follows the sequence type.
          state_d = S_REQ;
          lba_d   = lba_q + LBA_W'(1);
          rd_d    = loading_q;
          wr_d    = ~loading_q;
        end else begin
          state_d = S_XFER;
        end
      end
      S_FMT: begin
        if (fmt_addr_q == FMT_LAST) begin
          state_d    = S_IDLE;
          fmt_we_d   = 1'b0;
          fmt_addr_d = 8'd0;
        end else begin
          fmt_addr_d = fmt_addr_q + 8'd1;
        end
      end
      default: begin
        state_d    = S_IDLE;
        rd_d       = 1'b0;
        wr_d       = 1'b0;
        busy_d     = 1'b0;
        loading_d  = 1'b0;
        fmt_we_d   = 1'b0;
        fmt_addr_d = 8'd0;
      end
    endcase
  end

  assign bus.sd_lba     = 32'(lba_q);
  assign bus.sd_rd      = rd_q;
  assign bus.sd_wr      = wr_q;
  assign bus.bk_ena     = ena_q;
  assign bus.bk_pending = pend_q;
  assign bus.bk_busy    = busy_q;
  assign bus.bk_loading = loading_q;
  assign bus.fmt_we     = fmt_we_q;
  assign bus.fmt_addr   = fmt_addr_q;

endmodule

// File: tb/tb_bkram_seq.sv
// Randomized self-checking bench for bkram_seq: an HPS responder with random
// ack latency, plus a trigger-priority model predicting which sequence runs.
module tb_bkram_seq;
  localparam int SECTORS   = 16;
  localparam int FMT_WORDS = 4;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   rd_cyc, wr_cyc, both_cyc, fmt_cyc;
  int   b_rd, b_wr, b_fmt;

  bkram_seq_if bif();

  bkram_seq #(.SECTORS(SECTORS), .FMT_WORDS(FMT_WORDS)) dut (
    .clk_sys (clk),
    .reset   (rst),
    .bus     (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Activity counters for "never asserted" style checks.
  always @(posedge clk) begin
    if (bif.sd_rd) rd_cyc <= rd_cyc + 1;
    if (bif.sd_wr) wr_cyc <= wr_cyc + 1;
    if (bif.sd_rd && bif.sd_wr) both_cyc <= both_cyc + 1;
    if (bif.fmt_we) fmt_cyc <= fmt_cyc + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic snap();
    b_rd  = rd_cyc;
    b_wr  = wr_cyc;
    b_fmt = fmt_cyc;
  endtask

  task automatic check_quiet(input string tag);
    check_val({tag, "_rd"},      32'(bif.sd_rd),      32'd0);
    check_val({tag, "_wr"},      32'(bif.sd_wr),      32'd0);
    check_val({tag, "_lba"},     bif.sd_lba,          32'd0);
    check_val({tag, "_ena"},     32'(bif.bk_ena),     32'd0);
    check_val({tag, "_pend"},    32'(bif.bk_pending), 32'd0);
    check_val({tag, "_busy"},    32'(bif.bk_busy),    32'd0);
    check_val({tag, "_loading"}, 32'(bif.bk_loading), 32'd0);
    check_val({tag, "_fmt_we"},  32'(bif.fmt_we),     32'd0);
    check_val({tag, "_fmt_adr"}, 32'(bif.fmt_addr),   32'd0);
  endtask

  // Plays the HPS side for n_do sectors; expects lba 0,1,2,... in one direction.
  task automatic run_xfer(input logic is_rd, input int n_do, input logic poke);
    int k;
    for (int i = 0; i < n_do; i++) begin
      k = 0;
      while (!(bif.sd_rd || bif.sd_wr) && k < 40) begin
        @(negedge clk);
        k++;
      end
      check_val("req_seen", 32'(k < 40), 32'd1);
      if (i > 0) check_val("rereq_latency", 32'(k), 32'd0);
      check_val("req_rd",      32'(bif.sd_rd),      32'(is_rd));
      check_val("req_wr",      32'(bif.sd_wr),      32'(!is_rd));
      check_val("req_lba",     bif.sd_lba,          32'(i));
      check_val("req_busy",    32'(bif.bk_busy),    32'd1);
      check_val("req_loading", 32'(bif.bk_loading), 32'(is_rd));
      if (poke && i == 3) begin
        bif.load_req = 1'b1; bif.save_req = 1'b1; bif.format_req = 1'b1;
        @(negedge clk);
        bif.load_req = 1'b0; bif.save_req = 1'b0; bif.format_req = 1'b0;
        check_val("busy_trig_lba", bif.sd_lba, 32'(i));
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      bif.sd_ack = 1'b1;
      @(negedge clk);
      k = 1;
      while ((bif.sd_rd || bif.sd_wr) && k < 40) begin
        @(negedge clk);
        k++;
      end
      check_val("ack_drop_latency", 32'(k), 32'd1);
      check_val("xfer_busy", 32'(bif.bk_busy), 32'd1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      bif.sd_ack = 1'b0;
      @(negedge clk);
    end
    if (n_do == SECTORS) begin
      check_val("end_busy",    32'(bif.bk_busy),    32'd0);
      check_val("end_loading", 32'(bif.bk_loading), 32'd0);
      check_val("end_req",     32'(bif.sd_rd | bif.sd_wr), 32'd0);
    end
  endtask

  task automatic check_fmt();
    for (int a = 0; a < FMT_WORDS; a++) begin
      check_val("fmt_we",   32'(bif.fmt_we),   32'd1);
      check_val("fmt_addr", 32'(bif.fmt_addr), 32'(a));
      check_val("fmt_busy", 32'(bif.bk_busy),  32'd0);
      check_val("fmt_req",  32'(bif.sd_rd | bif.sd_wr), 32'd0);
      @(negedge clk);
    end
    check_val("fmt_end", 32'(bif.fmt_we), 32'd0);
  endtask

  initial begin
    logic [2:0] v;
    bif.download = 1'b0; bif.img_mounted = 1'b0; bif.img_readonly = 1'b0;
    bif.img_size_nz = 1'b0; bif.osd_status = 1'b0; bif.load_req = 1'b0;
    bif.save_req = 1'b0; bif.format_req = 1'b0; bif.autosave = 1'b0;
    bif.bram_wr = 1'b0; bif.sd_ack = 1'b0;
    rst = 1'b1;
    tick(2);
    check_quiet("reset");
    rst = 1'b0;
    tick(2);

    // Writable mount during download, then download end auto-loads all sectors.
    bif.download = 1'b1;
    tick(1);
    bif.img_mounted = 1'b1; bif.img_size_nz = 1'b1;
    tick(1);
    bif.img_mounted = 1'b0;
    check_val("ena_set", 32'(bif.bk_ena), 32'd1);
    bif.download = 1'b0;
    run_xfer(1'b1, SECTORS, 1'b1);
    tick(4);
    check_val("busy_trig_ignored", 32'(bif.sd_rd | bif.sd_wr | bif.fmt_we), 32'd0);

    // Empty image: no auto-load on download end.
    bif.download = 1'b1;
    tick(1);
    check_val("ena_clr_dl", 32'(bif.bk_ena), 32'd0);
    bif.img_mounted = 1'b1; bif.img_size_nz = 1'b0;
    tick(1);
    bif.img_mounted = 1'b0;
    snap();
    bif.download = 1'b0;
    tick(8);
    check_val("no_autoload_empty", 32'(rd_cyc - b_rd), 32'd0);
    check_val("ena_empty", 32'(bif.bk_ena), 32'd1);

    // Pending tracking and autosave on OSD open.
    tick(1); bif.bram_wr = 1'b1;
    tick(1); bif.bram_wr = 1'b0;
    check_val("pend_set", 32'(bif.bk_pending), 32'd1);
    snap();
    bif.osd_status = 1'b1;
    tick(6);
    check_val("no_autosave_off", 32'(wr_cyc - b_wr), 32'd0);
    check_val("pend_kept", 32'(bif.bk_pending), 32'd1);
    bif.osd_status = 1'b0; bif.autosave = 1'b1;
    repeat ($urandom_range(1, 3)) begin
      tick(1); bif.bram_wr = 1'b1;
      tick(1); bif.bram_wr = 1'b0;
    end
    tick(1);
    bif.osd_status = 1'b1;
    run_xfer(1'b0, SECTORS, 1'b0);
    check_val("pend_clr", 32'(bif.bk_pending), 32'd0);
    bif.bram_wr = 1'b1;
    tick(1); bif.bram_wr = 1'b0;
    tick(1);
    check_val("pend_osd_block", 32'(bif.bk_pending), 32'd0);
    bif.osd_status = 1'b0;
    tick(2);

    // Simultaneous triggers: model predicts load > save > format.
    for (int t = 0; t < 6; t++) begin
      v = (t == 0) ? 3'b011 : 3'($urandom_range(1, 7));
      snap();
      bif.load_req = v[0]; bif.save_req = v[1]; bif.format_req = v[2];
      tick(1);
      bif.load_req = 1'b0; bif.save_req = 1'b0; bif.format_req = 1'b0;
      if (v[0]) run_xfer(1'b1, SECTORS, 1'b0);
      else if (v[1]) run_xfer(1'b0, SECTORS, 1'b0);
      else check_fmt();
      tick(3);
      if (v[0]) begin
        check_val("pri_load_no_wr", 32'(wr_cyc - b_wr), 32'd0);
        check_val("pri_load_no_fmt", 32'(fmt_cyc - b_fmt), 32'd0);
      end else if (v[1]) begin
        check_val("pri_save_no_rd", 32'(rd_cyc - b_rd), 32'd0);
        check_val("pri_save_no_fmt", 32'(fmt_cyc - b_fmt), 32'd0);
      end else begin
        check_val("pri_fmt_no_xfer", 32'((rd_cyc - b_rd) + (wr_cyc - b_wr)), 32'd0);
      end
    end

    // Read-only image disables load/save entirely.
    bif.download = 1'b1;
    tick(1);
    bif.img_mounted = 1'b1; bif.img_readonly = 1'b1; bif.img_size_nz = 1'b1;
    tick(1);
    bif.img_mounted = 1'b0;
    check_val("ena_readonly", 32'(bif.bk_ena), 32'd0);
    snap();
    bif.download = 1'b0;
    tick(4);
    bif.load_req = 1'b1; tick(1); bif.load_req = 1'b0;
    tick(2);
    bif.save_req = 1'b1; tick(1); bif.save_req = 1'b0;
    tick(6);
    check_val("ro_no_rd", 32'(rd_cyc - b_rd), 32'd0);
    check_val("ro_no_wr", 32'(wr_cyc - b_wr), 32'd0);
    bif.img_readonly = 1'b0;

    // Format works without bk_ena.
    snap();
    bif.format_req = 1'b1; tick(1); bif.format_req = 1'b0;
    check_fmt();
    check_val("fmt_count", 32'(fmt_cyc - b_fmt), 32'(FMT_WORDS));

    // Reset in the middle of an auto-load.
    bif.download = 1'b1;
    tick(1);
    bif.img_mounted = 1'b1;
    tick(1);
    bif.img_mounted = 1'b0;
    check_val("ena_remount", 32'(bif.bk_ena), 32'd1);
    bif.download = 1'b0;
    run_xfer(1'b1, 5, 1'b0);
    check_val("mid_rd", 32'(bif.sd_rd), 32'd1);
    check_val("mid_lba", bif.sd_lba, 32'd5);
    rst = 1'b1;
    #1;
    check_quiet("midrst");
    tick(2);
    rst = 1'b0;
    snap();
    repeat (3) begin
      tick(2); bif.sd_ack = 1'b1;
      tick(2); bif.sd_ack = 1'b0;
    end
    tick(1);
    bif.load_req = 1'b1; tick(1); bif.load_req = 1'b0;
    tick(6);
    check_val("post_rst_no_xfer", 32'((rd_cyc - b_rd) + (wr_cyc - b_wr)), 32'd0);
    check_val("post_rst_busy", 32'(bif.bk_busy), 32'd0);
    check_val("never_both", 32'(both_cyc), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
